// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron.
package lif_pkg;

    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } lif_state_e;

    localparam int unsigned ADAPT_INC = 16;
    localparam int unsigned ADAPT_DEC = 1;
    localparam int unsigned V_MAX     = 255;

    // Width that holds the sum of n 8-bit activations without overflow.
    function automatic int sum_width(input int n);
        return 8 + $clog2(n);
    endfunction

endpackage

// File: rtl/lif_membrane_update.sv
// Combinational leak + integrate: v' = v - (v >> LEAK_SHIFT) + sum(words),
// clipped at V_MAX. Word k occupies bus bits 8k..8k+7, with bit 8k the MSB.
module lif_membrane_update
    import lif_pkg::*;
#(
    parameter int unsigned N_SYN      = 4,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic [N_SYN*8-1:0] activation_bus,
    input  logic [7:0]         v,
    output logic [7:0]         v_next
);

    localparam int SW = sum_width(N_SYN);

    logic [7:0]  word;
    logic [SW-1:0] sum;
    logic [SW:0]   total;

    // Unpack each word (bit 8k is its MSB), sum, leak, integrate and saturate.
    always_comb begin
        word  = '0;
        sum   = '0;
        total = '0;
        for (int k = 0; k < N_SYN; k++) begin
            for (int b = 0; b < 8; b++) begin
                word[7-b] = activation_bus[8*k+b];
            end
            sum = sum + SW'(word);
        end
        // v - (v >> LEAK_SHIFT) never goes negative, so only the top can overflow.
        total  = (SW+1)'(v) - (SW+1)'(v >> LEAK_SHIFT) + (SW+1)'(sum);
        v_next = (total > (SW+1)'(V_MAX)) ? 8'(V_MAX) : total[7:0];
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with a programmable refractory period.
// Optional feature macro: LIF_ADAPT_EN (adaptive firing threshold).
// Valid/ready note: there is no backpressure; `step` is a one-cycle qualifier
// and every cycle with step=1 is consumed as exactly one time step.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int unsigned N_SYN         = 4,
    parameter int unsigned THRESHOLD     = 200,
    parameter int unsigned LEAK_SHIFT    = 3,
    parameter int unsigned REFRACT_STEPS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic [N_SYN*8-1:0] activation_bus,
    output logic               post_spike,
    output logic [7:0]         membrane,
    output logic               refractory
);

    lif_state_e state;
    logic [3:0] count;
    logic [7:0] v_next;
    logic [7:0] thr;
    logic       fire;

    lif_membrane_update #(
        .N_SYN      (N_SYN),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .activation_bus (activation_bus),
        .v              (membrane),
        .v_next         (v_next)
    );

    assign fire       = (state == INTEGRATE) && (v_next >= thr);
    assign refractory = (state == REFRACT);

`ifdef LIF_ADAPT_EN
    logic [7:0] thr_q;
    assign thr = thr_q;

    // Adaptive threshold: jump up on a spike, relax by one per quiet step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_q <= 8'(THRESHOLD);
        end else if (step) begin
            if (fire) begin
                thr_q <= (thr_q > 8'(V_MAX - ADAPT_INC)) ? 8'(V_MAX) : thr_q + 8'(ADAPT_INC);
            end else if (thr_q > 8'(THRESHOLD)) begin
                thr_q <= thr_q - 8'(ADAPT_DEC);
            end
        end
    end
`else
    assign thr = 8'(THRESHOLD);
`endif

    // Neuron FSM: integrate/fire, then discard REFRACT_STEPS steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INTEGRATE;
            membrane   <= 8'd0;
            post_spike <= 1'b0;
            count      <= 4'd0;
        end else begin
            post_spike <= 1'b0;
            if (step) begin
                case (state)
                    INTEGRATE: begin
                        if (fire) begin
                            membrane   <= 8'd0;
                            post_spike <= 1'b1;
                            count      <= 4'(REFRACT_STEPS);
                            if (REFRACT_STEPS != 0) state <= REFRACT;
                        end else begin
                            membrane <= v_next;
                        end
                    end
                    REFRACT: begin
                        // The step that brings count to zero is still discarded.
                        membrane <= 8'd0;
                        count    <= count - 4'd1;
                        if (count == 4'd1) state <= INTEGRATE;
                    end
                    default: state <= INTEGRATE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron (default, REFRACT_STEPS=0, THRESHOLD=255).
`timescale 1ns/1ps
module tb_lif_neuron;

    localparam int RS  = 2;
    localparam int THR = 200;

    logic        clk;
    logic        reset;
    logic        step;
    logic [31:0] bus;

    logic       post_spike, refractory;
    logic [7:0] membrane;
    logic       ps_r0, ref_r0;
    logic [7:0] mem_r0;
    logic       ps_sat, ref_sat;
    logic [7:0] mem_sat;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];

    // reference model state for the default instance
    int   m_v, m_cnt, m_thr;
    logic m_refr;

    lif_neuron #(.N_SYN(4), .THRESHOLD(THR), .LEAK_SHIFT(3), .REFRACT_STEPS(RS)) dut (
        .clk(clk), .reset(reset), .step(step), .activation_bus(bus),
        .post_spike(post_spike), .membrane(membrane), .refractory(refractory));

    lif_neuron #(.N_SYN(4), .THRESHOLD(THR), .LEAK_SHIFT(3), .REFRACT_STEPS(0)) dut_r0 (
        .clk(clk), .reset(reset), .step(step), .activation_bus(bus),
        .post_spike(ps_r0), .membrane(mem_r0), .refractory(ref_r0));

    lif_neuron #(.N_SYN(4), .THRESHOLD(255), .LEAK_SHIFT(3), .REFRACT_STEPS(RS)) dut_sat (
        .clk(clk), .reset(reset), .step(step), .activation_bus(bus),
        .post_spike(ps_sat), .membrane(mem_sat), .refractory(ref_sat));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        step  = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        m_v    = 0;
        m_cnt  = 0;
        m_thr  = THR;
        m_refr = 1'b0;
    endtask

    // words: word0 in [31:24] ... word3 in [7:0]; bus bit 8k is MSB of word k
    task automatic apply_step(input logic [31:0] words, input logic [9:0] e);
        @(negedge clk);
        step = 1'b1;
        for (int i = 0; i < 32; i++) bus[i] = words[31-i];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step = 1'b0;
        bus  = $urandom;
    endtask

    task automatic model_step(input logic [31:0] words, output logic [9:0] e);
        int   s, vn;
        logic spike;
        spike = 1'b0;
        if (m_refr) begin
            m_v = 0;
            m_cnt--;
            if (m_cnt == 0) m_refr = 1'b0;
        end else begin
            s = 0;
            for (int k = 0; k < 4; k++) s += int'(words[31-8*k -: 8]);
            vn = m_v - (m_v >> 3) + s;
            if (vn > 255) vn = 255;
            if (vn >= m_thr) begin
                spike = 1'b1;
                m_v   = 0;
                if (RS != 0) begin
                    m_refr = 1'b1;
                    m_cnt  = RS;
                end
            end else begin
                m_v = vn;
            end
        end
`ifdef LIF_ADAPT_EN
        if (spike) m_thr = (m_thr + 16 > 255) ? 255 : m_thr + 16;
        else if (m_thr > THR) m_thr--;
`endif
        e = {spike, m_refr, 8'(m_v)};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step  = 1'b0;
        bus   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        m_v = 0; m_cnt = 0; m_thr = THR; m_refr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({post_spike, refractory, membrane} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_dut got=%h exp=000", {post_spike, refractory, membrane});
        end
        n_cmp++;
        if ({ps_r0, ref_r0, mem_r0} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_r0 got=%h exp=000", {ps_r0, ref_r0, mem_r0});
        end
        n_cmp++;
        if ({ps_sat, ref_sat, mem_sat} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_sat got=%h exp=000", {ps_sat, ref_sat, mem_sat});
        end
    endtask

    task automatic test_integrate_fire();
        logic [9:0] e, got;
        apply_step(32'h20202020, {1'b0, 1'b0, 8'd128});
        got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL fire_step1 got=%h exp=%h", got, e); end
        apply_step(32'h20202020, {1'b1, 1'b1, 8'd0});
        got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL fire_step2 got=%h exp=%h", got, e); end
`ifdef LIF_ADAPT_EN
        n_cmp++;
        if (dut.thr_q !== 8'd216) begin n_err++; $display("FAIL adapt_inc got=%0d exp=216", dut.thr_q); end
`endif
        n_cmp++;
        if ({ps_r0, ref_r0} !== 2'b10) begin n_err++; $display("FAIL r0_fire got=%b exp=10", {ps_r0, ref_r0}); end
        n_cmp++;
        if (mem_sat !== 8'd240) begin n_err++; $display("FAIL sat_below_thr got=%0d exp=240", mem_sat); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (post_spike !== 1'b0) begin n_err++; $display("FAIL spike_width got=%b exp=0", post_spike); end
    endtask

    task automatic test_refractory();
        logic [9:0] e, got;
        logic [9:0] tbl[3];
        tbl[0] = {1'b0, 1'b1, 8'd0};
        tbl[1] = {1'b0, 1'b0, 8'd0};
        tbl[2] = {1'b0, 1'b0, 8'd128};
        for (int i = 0; i < 3; i++) begin
            apply_step(32'h20202020, tbl[i]);
            got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL refract_step%0d got=%h exp=%h", i, got, e); end
`ifdef LIF_ADAPT_EN
            if (i == 0) begin
                n_cmp++;
                if (dut.thr_q !== 8'd215) begin n_err++; $display("FAIL adapt_dec got=%0d exp=215", dut.thr_q); end
            end
`endif
            n_cmp++;
            if (ref_r0 !== 1'b0) begin n_err++; $display("FAIL r0_refractory step%0d got=1 exp=0", i); end
        end
    endtask

    task automatic test_leak_hold();
        logic [9:0] e, got;
        logic [7:0] lv[4];
        logic [31:0] lw[4];
        lv[0] = 8'd128; lv[1] = 8'd112; lv[2] = 8'd98; lv[3] = 8'd86;
        lw[0] = 32'h20202020; lw[1] = 32'h0; lw[2] = 32'h0; lw[3] = 32'h0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_step(lw[i], {1'b0, 1'b0, lv[i]});
            got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL leak_step%0d got=%h exp=%h", i, got, e); end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus = $urandom;
            @(posedge clk);
            #1;
            n_cmp++;
            if (membrane !== 8'd86) begin n_err++; $display("FAIL hold_cycle%0d got=%0d exp=86", c, membrane); end
        end
    endtask

    task automatic test_word_order();
        logic [9:0] e, got;
        do_reset();
        // a bit-reversed unpack would give 192+160+8 = 360 and fire
        apply_step(32'h03051000, {1'b0, 1'b0, 8'd24});
        got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL word_order got=%h exp=%h", got, e); end
    endtask

    task automatic test_saturation();
        logic [9:0] e, got;
        do_reset();
        apply_step(32'hFFFFFFFF, {1'b1, 1'b1, 8'd0});
        got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL sat_dut got=%h exp=%h", got, e); end
        n_cmp++;
        if ({ps_sat, ref_sat, mem_sat} !== {1'b1, 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL sat_clip got=%h exp=300", {ps_sat, ref_sat, mem_sat});
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] e, got;
        // reset while post_spike is high
        do_reset();
        apply_step(32'h20202020, {1'b0, 1'b0, 8'd128}); void'(exp_q.pop_front());
        apply_step(32'h20202020, {1'b1, 1'b1, 8'd0});
        got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL async_pre_spike got=%h exp=%h", got, e); end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({post_spike, refractory, membrane} !== 10'd0) begin
            n_err++;
            $display("FAIL async_spike got=%h exp=000", {post_spike, refractory, membrane});
        end
`ifdef LIF_ADAPT_EN
        n_cmp++;
        if (dut.thr_q !== 8'd200) begin n_err++; $display("FAIL adapt_reset got=%0d exp=200", dut.thr_q); end
`endif
        // reset while in REFRACT, membrane nonzero beforehand
        do_reset();
        apply_step(32'h20202020, {1'b0, 1'b0, 8'd128}); void'(exp_q.pop_front());
        apply_step(32'h20202020, {1'b1, 1'b1, 8'd0});   void'(exp_q.pop_front());
        apply_step(32'h20202020, {1'b0, 1'b1, 8'd0});
        got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL async_pre_refract got=%h exp=%h", got, e); end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({refractory, membrane} !== 9'd0) begin
            n_err++;
            $display("FAIL async_refract got=%h exp=000", {refractory, membrane});
        end
        @(negedge clk);
        reset = 1'b1;
        apply_step(32'h20202020, {1'b0, 1'b0, 8'd128});
        got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL post_reset_step got=%h exp=%h", got, e); end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  e, got;
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            w = {8'($urandom_range(0, 90)), 8'($urandom_range(0, 90)),
                 8'($urandom_range(0, 90)), 8'($urandom_range(0, 90))};
            model_step(w, e);
            apply_step(w, e);
            got = {post_spike, refractory, membrane}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL b2b_step%0d got=%h exp=%h", i, got, e); end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                n_cmp++;
                if ({post_spike, membrane} !== {1'b0, 8'(m_v)}) begin
                    n_err++;
                    $display("FAIL b2b_idle%0d got=%h exp=%h", i, {post_spike, membrane}, {1'b0, 8'(m_v)});
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        step = 1'b0;
        bus  = '0;
        test_reset();
        test_integrate_fire();
        test_refractory();
        test_leak_hold();
        test_word_order();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
